simd_regfile_sequencer: RTL and testbench
=========================================

# simd_regfile_sequencer

Initiator side of the 32-entry, 16-bit SIMD register file. The block accepts one instruction at a time over a valid/ready handshake. For each instruction it drives the register file's read port to fetch both operands, computes a packed two-lane 8-bit (or one-lane 16-bit) result, and drives the write port to commit the result to `rd`. It sits between the instruction issue logic and the register file; its port names on the register-file side match the register file one-to-one.

## Interface
Parameters:
- `AW`, 5, register address width (32 entries).
- `DW`, 16, data width; two 8-bit lanes, lane1 = [15:8], lane0 = [7:0].

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  an instruction is offered.
- `instr_ready`  out  1  block can accept an instruction.
- `instr_op`  in  3  operation code, see Operation.
- `instr_rs1`, `instr_rs2`, `instr_rd`  in  AW  source and destination addresses.
- `rs1`, `rs2`, `rd`  out  AW  register-file addresses.
- `rs1_rd_en`, `rs2_rd_en`  out  1  register-file read enables.
- `rs1_data`, `rs2_data`  in  DW  register-file read data. These are combinational; x0 reads as 0.
- `rd_wr_en`  out  1  register-file write enable.
- `wr_data`  out  DW  write data.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `result`  out  DW  last computed result, held until the next EXEC.

## Operation
- FSM states are IDLE, READ, EXEC and WRITE.
- **IDLE:**
  - `instr_ready`=1.
  - If `instr_valid`, latch op, rs1, rs2 and rd, then go to READ.
- **READ:**
  - `rs1_rd_en`=`rs2_rd_en`=1.
  - `rs1`/`rs2` carry the latched addresses.
  - At the clock edge, capture `rs1_data`/`rs2_data` into operand registers A and B, then go to EXEC.
- **EXEC:**
  - The ALU result is registered into `result`.
  - Go to WRITE.
- **WRITE:**
  - `rd` carries the latched address and `wr_data`=`result`.
  - `rd_wr_en`=1 unless the latched rd==0. A write to x0 is suppressed, with `rd_wr_en` held at 0.
  - `done`=1 in both cases.
  - Go to IDLE.
- `instr_ready` is 0 in READ, EXEC and WRITE. `instr_valid` is ignored outside IDLE.
- Read enables are 0 outside READ. `rd_wr_en` is 0 outside WRITE. Address outputs hold their latched values in every state.
- Op codes:
  - 0 ADD16: 16-bit add, wraps mod 2^16.
  - 1 ADD8: per-lane add, wraps mod 256, no carry between lanes.
  - 2 SUB8: per-lane A−B, wraps.
  - 3 ADDS8: per-lane unsigned saturating add; a sum above 0xFF gives 0xFF.
  - 4 MAX8: per-lane unsigned maximum.
  - 5 AND, 6 OR, 7 XOR: bitwise over 16 bits.
- rs1==rs2 is legal; both ports read the same register.
- rd may equal rs1 or rs2. The operands are already captured before WRITE.

## Timing
- If accepted at edge N (IDLE, valid=1), the block is in READ during cycle N+1, EXEC during N+2 and WRITE during N+3. `instr_ready` returns to 1 in cycle N+4.
- Throughput is one instruction per 4 cycles.
- Read-after-write needs no forwarding. The register file commits at the edge ending WRITE, and the next READ happens at least 2 cycles later.
- Reset (`rst_n`=0 at an edge) forces:
  - state to IDLE;
  - the op/address latches, operand registers, `result`, `rs1`, `rs2` and `rd` to 0;
  - `done`, `rd_wr_en`, `rs1_rd_en` and `rs2_rd_en` to 0;
  - `instr_ready` to 1 in the first cycle after reset is released.
- Reset in any state aborts the instruction. No write is issued and there is no `done` pulse.

## Structure
- Shared package `simd_pkg` holds:
  - the op-code localparams `OP_ADD16` … `OP_XOR`;
  - the FSM state encoding `ST_IDLE`, `ST_READ`, `ST_EXEC`, `ST_WRITE`;
  - the `AW`/`DW` defaults.
- One combinational sub-module, `simd_alu16`, computes the result from (op, a, b). The sequencer holds the FSM, latches and port drivers.

## Test plan
- **ADD8 with saturation edge:** r1=0x7F01, r2=0x0102, op ADD8 rd=3 → one WRITE cycle with rd=3, `wr_data`=0x8003, `done`=1. Accept-to-write is exactly 3 cycles.
- **ADDS8 and SUB8:** r1=0xF010, r2=0x20F5.
  - ADDS8 → 0xFFFF.
  - SUB8 with r1=0x0005, r2=0x0106 → 0xFFFF.
  - MAX8 with r1=0x1280, r2=0x3401 → 0x3480.
- **x0 handling:** rs1=0, rs2=5 (0x1234), op OR, rd=0 → `result`=0x1234, `done`=1, `rd_wr_en` stays 0 for the whole instruction.
- **Back-to-back:** `instr_valid` held 1 with two instructions. The first is accepted at N, the second at N+4. The second reads the value written by the first: ADD16 r4=r1+r2, then XOR r5=r4^r4 gives 0x0000.
- **Mid-operation reset:** assert `rst_n`=0 during EXEC → `rd_wr_en`, `done` and the read enables stay 0. `instr_ready`=1 one cycle after release. The register file is unchanged.
- **Protocol:** toggle `instr_valid` while busy → no extra accept, and latched fields do not change until IDLE.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD register-file sequencer and its ALU.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package simd_pkg;

  // Register-file geometry defaults: 32 entries of two 8-bit lanes.
  localparam int AW_DEFAULT = 5;
  localparam int DW_DEFAULT = 16;

  // Operation codes carried on instr_op.
  localparam logic [2:0] OP_ADD16 = 3'd0;
  localparam logic [2:0] OP_ADD8  = 3'd1;
  localparam logic [2:0] OP_SUB8  = 3'd2;
  localparam logic [2:0] OP_ADDS8 = 3'd3;
  localparam logic [2:0] OP_MAX8  = 3'd4;
  localparam logic [2:0] OP_AND   = 3'd5;
  localparam logic [2:0] OP_OR    = 3'd6;
  localparam logic [2:0] OP_XOR   = 3'd7;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Unsigned 8-bit add that clamps at 0xFF instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Unsigned 8-bit maximum.
  function automatic logic [7:0] max8(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/simd_alu16.sv
// Two-lane 8-bit / one-lane 16-bit SIMD ALU selected by op.
// Latency: purely combinational, result valid in the same cycle as inputs.
// Backpressure: none; the caller decides when to sample y.
module simd_alu16
  import simd_pkg::*;
(
  input  logic [2:0]            op,
  input  logic [DW_DEFAULT-1:0] a,
  input  logic [DW_DEFAULT-1:0] b,
  output logic [DW_DEFAULT-1:0] y
);

  logic [7:0] a_hi, a_lo, b_hi, b_lo;

  assign a_hi = a[15:8];
  assign a_lo = a[7:0];
  assign b_hi = b[15:8];
  assign b_lo = b[7:0];

  // Lane ops never carry or borrow across the lane boundary.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD16: y = a + b;
      OP_ADD8:  y = {8'(a_hi + b_hi), 8'(a_lo + b_lo)};
      OP_SUB8:  y = {8'(a_hi - b_hi), 8'(a_lo - b_lo)};
      OP_ADDS8: y = {sat_add8(a_hi, b_hi), sat_add8(a_lo, b_lo)};
      OP_MAX8:  y = {max8(a_hi, b_hi), max8(a_lo, b_lo)};
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/simd_regfile_sequencer.sv
// Runs one SIMD instruction at a time: read both operands, execute, write rd.
// Latency: accept -> READ -> EXEC -> WRITE, retiring 3 cycles after accept; one instruction per 4 cycles.
// Backpressure: instr_ready is low from accept until the cycle after WRITE; instr_valid is ignored while busy.
module simd_regfile_sequencer
  import simd_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [AW-1:0] instr_rd,
  output logic [AW-1:0] rs1,
  output logic [AW-1:0] rs2,
  output logic [AW-1:0] rd,
  output logic          rs1_rd_en,
  output logic          rs2_rd_en,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rs2_data,
  output logic          rd_wr_en,
  output logic [DW-1:0] wr_data,
  output logic          done,
  output logic [DW-1:0] result
);

  state_t        state;
  logic [2:0]    op_q;
  logic [DW-1:0] opa_q;
  logic [DW-1:0] opb_q;
  logic [DW-1:0] alu_y;

  simd_alu16 u_alu (
    .op (op_q),
    .a  (opa_q),
    .b  (opb_q),
    .y  (alu_y)
  );

  // Write data is simply the registered result; it is only consumed in WRITE.
  assign wr_data = result;

  // Sequencer FSM; every handshake and register-file strobe is registered and
  // set one state ahead so it is asserted for exactly the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result      <= '0;
      instr_ready <= 1'b1;
      rs1_rd_en   <= 1'b0;
      rs2_rd_en   <= 1'b0;
      rd_wr_en    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            rs1         <= instr_rs1;
            rs2         <= instr_rs2;
            rd          <= instr_rd;
            instr_ready <= 1'b0;
            rs1_rd_en   <= 1'b1;
            rs2_rd_en   <= 1'b1;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          // Register-file data is combinational on the latched addresses.
          opa_q     <= rs1_data;
          opb_q     <= rs2_data;
          rs1_rd_en <= 1'b0;
          rs2_rd_en <= 1'b0;
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          result   <= alu_y;
          // x0 is hardwired to zero, so a write there is dropped but still retires.
          rd_wr_en <= (rd != '0);
          done     <= 1'b1;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          rd_wr_en    <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simd_regfile_sequencer.sv
// Self-checking bench: behavioural register file plus a lane-arithmetic reference model.
// Latency: checks every cycle of each instruction against the fixed 4-cycle schedule.
// Backpressure: drives instr_valid while busy to confirm it is ignored.
module tb_simd_regfile_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rs1, instr_rs2, instr_rd;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_rd_en, rs2_rd_en;
  logic [15:0] rs1_data, rs2_data;
  logic        rd_wr_en;
  logic [15:0] wr_data;
  logic        done;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  // Register file as seen by the DUT, plus a bench-side preload port.
  logic [15:0] rf [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [15:0] pre_dat;

  // Reference register contents, updated from the instruction semantics only.
  logic [15:0] ref_regs [32];

  simd_regfile_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_rd    (instr_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .rs1_rd_en   (rs1_rd_en),
    .rs2_rd_en   (rs2_rd_en),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_wr_en    (rd_wr_en),
    .wr_data     (wr_data),
    .done        (done),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reads return junk unless enabled, so a mistimed operand capture shows up.
  assign rs1_data = !rs1_rd_en ? 16'hBAD1 : (rs1 == 5'd0) ? 16'h0000 : rf[rs1];
  assign rs2_data = !rs2_rd_en ? 16'hBAD2 : (rs2 == 5'd0) ? 16'h0000 : rf[rs2];

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_dat;
    else if (rd_wr_en && rd != 5'd0) rf[rd] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
    int ah, al, bh, bl, h, l;
    ah = a / 256; al = a % 256; bh = b / 256; bl = b % 256;
    h = 0; l = 0;
    case (op)
      0: return 16'((a + b) % 65536);
      1: begin h = (ah + bh) % 256; l = (al + bl) % 256; end
      2: begin h = (ah - bh + 256) % 256; l = (al - bl + 256) % 256; end
      3: begin h = (ah + bh > 255) ? 255 : ah + bh; l = (al + bl > 255) ? 255 : al + bl; end
      4: begin h = (ah > bh) ? ah : bh; l = (al > bl) ? al : bl; end
      5: return 16'(a & b);
      6: return 16'(a | b);
      default: return 16'(a ^ b);
    endcase
    return 16'(h * 256 + l);
  endfunction

  // Preload one register (DUT must be idle).
  task automatic set_reg(input logic [4:0] addr, input logic [15:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_dat = val;
    @(negedge clk);
    pre_we = 1'b0;
    if (addr != 5'd0) ref_regs[addr] = val;
  endtask

  task automatic drive_busy(input bit noise);
    if (noise) begin
      instr_valid = 1'($urandom);
      instr_op    = 3'($urandom);
      instr_rs1   = 5'($urandom);
      instr_rs2   = 5'($urandom);
      instr_rd    = 5'($urandom);
    end else begin
      instr_valid = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge inside WRITE.
  task automatic run_instr(input logic [2:0] op, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] d, input bit noise, input bit keep_valid,
                           input bit chained);
    logic [15:0] exp;
    int wait_cnt;
    exp = ref_alu(int'(op), int'(ref_regs[a1]), int'(ref_regs[a2]));
    instr_valid = 1'b1; instr_op = op; instr_rs1 = a1; instr_rs2 = a2; instr_rd = d;
    wait_cnt = 0;
    while (!instr_ready && wait_cnt < 8) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    if (chained) check("b2b_gap", 32'(wait_cnt), 32'd1);
    @(posedge clk);
    #1 drive_busy(noise);
    @(negedge clk);
    check("read_en1", 32'(rs1_rd_en), 32'd1);
    check("read_en2", 32'(rs2_rd_en), 32'd1);
    check("read_rs1", 32'(rs1), 32'(a1));
    check("read_rs2", 32'(rs2), 32'(a2));
    check("read_busy", 32'(instr_ready), 32'd0);
    check("read_nowr", 32'({rd_wr_en, done}), 32'd0);
    @(posedge clk);
    #1 drive_busy(noise);
    @(negedge clk);
    check("exec_strobes", 32'({rs1_rd_en, rs2_rd_en, rd_wr_en, done, instr_ready}), 32'd0);
    @(posedge clk);
    #1 drive_busy(noise);
    @(negedge clk);
    check("wr_done", 32'(done), 32'd1);
    check("wr_en", 32'(rd_wr_en), 32'(d != 5'd0));
    check("wr_rd", 32'(rd), 32'(d));
    check("wr_data", 32'(wr_data), 32'(exp));
    check("wr_result", 32'(result), 32'(exp));
    check("wr_ctrl", 32'({rs1_rd_en, rs2_rd_en, instr_ready}), 32'd0);
    if (d != 5'd0) ref_regs[d] = exp;
    instr_valid = keep_valid;
  endtask

  task automatic idle_gap(input int n);
    instr_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_ready", 32'(instr_ready), 32'd1);
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit chain;
    int g;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_rd = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    for (int i = 0; i < 32; i++) begin rf[i] = '0; ref_regs[i] = '0; end
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_strobes", 32'({rs1_rd_en, rs2_rd_en, rd_wr_en, done}), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_addrs", 32'({rs1, rs2, rd}), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) set_reg(5'(i), 16'($urandom));

    // Directed lane-arithmetic vectors.
    set_reg(5'd1, 16'h7F01); set_reg(5'd2, 16'h0102);
    run_instr(3'd1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    check("add8_vec", 32'(wr_data), 32'h8003);
    idle_gap(1);
    set_reg(5'd1, 16'hF010); set_reg(5'd2, 16'h20F5);
    run_instr(3'd3, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
    check("adds8_vec", 32'(wr_data), 32'hFFFF);
    idle_gap(1);
    set_reg(5'd1, 16'h0005); set_reg(5'd2, 16'h0106);
    run_instr(3'd2, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0);
    check("sub8_vec", 32'(wr_data), 32'hFFFF);
    idle_gap(1);
    set_reg(5'd1, 16'h1280); set_reg(5'd2, 16'h3401);
    run_instr(3'd4, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0);
    check("max8_vec", 32'(wr_data), 32'h3480);
    idle_gap(1);

    // x0 source and destination.
    set_reg(5'd5, 16'h1234);
    run_instr(3'd6, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    check("x0_result", 32'(result), 32'h1234);
    idle_gap(1);

    // Back-to-back with read-after-write.
    run_instr(3'd0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1, 1'b0);
    run_instr(3'd7, 5'd4, 5'd4, 5'd5, 1'b0, 1'b1, 1'b1);
    check("b2b_xor", 32'(wr_data), 32'h0000);
    run_instr(3'd0, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1);
    check("b2b_raw", 32'(wr_data), 32'(16'h1280 + 16'h3401));
    idle_gap(1);

    // Busy-time valid toggling must not disturb the latched instruction.
    run_instr(3'd1, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
    idle_gap(2);

    // Reset during EXEC aborts without write or done.
    instr_valid = 1'b1; instr_op = 3'd0; instr_rs1 = 5'd1; instr_rs2 = 5'd2; instr_rd = 5'd12;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_strobes", 32'({rs1_rd_en, rs2_rd_en, rd_wr_en, done}), 32'd0);
    check("mrst_result", 32'(result), 32'd0);
    check("mrst_rd", 32'(rd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready", 32'(instr_ready), 32'd1);
    check("mrst_post", 32'({rs1_rd_en, rs2_rd_en, rd_wr_en, done}), 32'd0);

    // Randomised instruction stream.
    chain = 1'b0;
    for (int i = 0; i < 40; i++) begin
      g = $urandom_range(0, 2);
      run_instr(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                1'($urandom), (g == 0) && (i < 39), chain);
      chain = (g == 0) && (i < 39);
      if (!chain) idle_gap((g == 0) ? 1 : g);
    end

    for (int i = 1; i < 32; i++) check("rf_final", 32'(rf[i]), 32'(ref_regs[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
